uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_fifo.sv | 80 ++++++++
 rtl/uart_rx_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive controller.
//   rx_state_e    - controller state encoding (IDLE / START / RUN)
//   STRB_W        - width of the per-frame strobe counter (max 1+15+1+3 = 20)
//   MIN_DIV       - smallest divisor the controller will run with
//   frame_strobes - total strobes in a frame for a given configuration
package uart_pkg;

  localparam int MIN_DIV = 4;
  localparam int STRB_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } rx_state_e;

  // start strobe + data bits + optional parity + stop bits
  function automatic logic [STRB_W-1:0] frame_strobes(
    input logic [3:0] data_size,
    input logic       parity_size,
    input logic [1:0] stop_size
  );
    return STRB_W'(1) + STRB_W'(data_size) + STRB_W'(parity_size) + STRB_W'(stop_size);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO with sticky overrun flag.
//   clk_i, rst_i       - clock, synchronous active-high reset
//   push_i, push_data_i- write request and 10-bit entry {err, data[8:0]}
//   pop_req_i          - reader ready; pops only when the FIFO is non-empty
//   clr_overrun_i      - clears overrun_o (a same-cycle overrun wins)
//   rd_valid_o         - head entry valid (registered state, no path from pop_req_i)
//   rd_data_o          - head entry
//   overrun_o          - sticky: a push was dropped because the FIFO was full
//   level_o            - occupancy, 0..DEPTH
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [9:0]               push_data_i,
  input  logic                     pop_req_i,
  input  logic                     clr_overrun_i,
  output logic                     rd_valid_o,
  output logic [9:0]               rd_data_o,
  output logic                     overrun_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overrun;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr;
  logic w_ovf;

  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = pop_req_i & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr    = push_i & (~w_full | w_pop);
  assign w_ovf   = push_i & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_ovf) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rd_valid_o = ~w_empty;
  assign rd_data_o  = r_mem[r_rd_ptr];
  assign overrun_o  = r_overrun;
  assign level_o    = r_level;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller. Synchronises the serial line, finds
// the start bit, times mid-bit sample strobes for an external rx datapath,
// and buffers the datapath's finished words in a FIFO.
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   rx_i                         - asynchronous serial line (idle high)
//   baud_div_i                   - clock cycles per bit (values below 4 act as 4)
//   data/parity/stop config in   - frame configuration, latched at frame start
//   rx_en_o, rx_o                - sample strobe and synchronised line level
//   data/parity/stop config out  - latched configuration for the datapath
//   data_i, rx_rdy_i, rx_err_i   - datapath word, done level, error flag
//   rd_valid_o/rd_data_o/rd_err_o/rd_ready_i - FIFO read handshake
//   overrun_o, clr_overrun_i     - sticky drop flag and its clear
//   level_o                      - FIFO occupancy
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic [3:0]                    data_size_i,
  input  logic                          parity_size_i,
  input  logic                          parity_type_i,
  input  logic [1:0]                    stop_size_i,
  output logic                          rx_en_o,
  output logic                          rx_o,
  output logic [3:0]                    data_size_o,
  output logic                          parity_size_o,
  output logic                          parity_type_o,
  output logic [1:0]                    stop_size_o,
  input  logic [8:0]                    data_i,
  input  logic                          rx_rdy_i,
  input  logic                          rx_err_i,
  output logic                          rd_valid_o,
  output logic [8:0]                    rd_data_o,
  output logic                          rd_err_o,
  input  logic                          rd_ready_i,
  output logic                          overrun_o,
  input  logic                          clr_overrun_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  logic              r_sync1;
  logic              r_sync2;
  rx_state_e         r_state;
  rx_state_e         w_state_next;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  w_cnt_next;
  logic [STRB_W-1:0] r_strb;
  logic [STRB_W-1:0] w_strb_next;
  logic              r_rx_en;
  logic              w_rx_en_next;
  logic [3:0]        r_data_size;
  logic              r_parity_size;
  logic              r_parity_type;
  logic [1:0]        r_stop_size;
  logic              r_rdy_d;

  logic [DIV_W-1:0]  w_div_eff;
  logic [DIV_W-1:0]  w_half_m1;
  logic [DIV_W-1:0]  w_div_m1;
  logic [STRB_W-1:0] w_total;
  logic              w_start;
  logic              w_push;
  logic [9:0]        w_rd_word;

  assign w_div_eff = (baud_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div_i;
  assign w_half_m1 = (r_div >> 1) - DIV_W'(1);
  assign w_div_m1  = r_div - DIV_W'(1);
  assign w_total   = frame_strobes(r_data_size, r_parity_size, r_stop_size);
  assign w_start   = (r_state == ST_IDLE) & ~r_sync2;
  assign w_push    = rx_rdy_i & ~r_rdy_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_strb        <= '0;
      r_rx_en       <= 1'b0;
      r_div         <= DIV_W'(MIN_DIV);
      r_data_size   <= '0;
      r_parity_size <= 1'b0;
      r_parity_type <= 1'b0;
      r_stop_size   <= '0;
      r_rdy_d       <= 1'b0;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_strb  <= w_strb_next;
      r_rx_en <= w_rx_en_next;
      r_rdy_d <= rx_rdy_i;
      if (w_start) begin
        r_div         <= w_div_eff;
        r_data_size   <= data_size_i;
        r_parity_size <= parity_size_i;
        r_parity_type <= parity_type_i;
        r_stop_size   <= stop_size_i;
      end
    end
  end

  // The strobe is registered: it is decided on the terminal-count cycle and
  // is visible to the datapath during the following cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_strb_next  = r_strb;
    w_rx_en_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (~r_sync2) begin
          w_state_next = ST_START;
          w_cnt_next   = '0;
          w_strb_next  = '0;
        end
      end
      ST_START: begin
        if (r_cnt == w_half_m1) begin
          w_cnt_next = '0;
          // Line back high at the middle of the start bit: treat as a glitch.
          if (r_sync2) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_RUN;
            w_rx_en_next = 1'b1;
            w_strb_next  = STRB_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + DIV_W'(1);
        end
      end
      ST_RUN: begin
        if (r_strb == w_total) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == w_div_m1) begin
          w_cnt_next   = '0;
          w_rx_en_next = 1'b1;
          w_strb_next  = r_strb + STRB_W'(1);
        end else begin
          w_cnt_next = r_cnt + DIV_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (w_push),
    .push_data_i   ({rx_err_i, data_i}),
    .pop_req_i     (rd_ready_i),
    .clr_overrun_i (clr_overrun_i),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (w_rd_word),
    .overrun_o     (overrun_o),
    .level_o       (level_o)
  );

  assign rx_en_o       = r_rx_en;
  assign rx_o          = r_sync2;
  assign data_size_o   = r_data_size;
  assign parity_size_o = r_parity_size;
  assign parity_type_o = r_parity_type;
  assign stop_size_o   = r_stop_size;
  assign rd_err_o      = w_rd_word[9];
  assign rd_data_o     = w_rd_word[8:0];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl.
// FIFO behaviour is driven from a vector table; frame timing, glitch reject,
// minimum divisor and mid-frame reset are hand-written sequences. Expected
// FIFO words go into a scoreboard queue when pushed and are compared on pop.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          rx_i;
  logic [DW-1:0] baud_div_i;
  logic [3:0]    data_size_i;
  logic          parity_size_i;
  logic          parity_type_i;
  logic [1:0]    stop_size_i;
  logic          rx_en_o;
  logic          rx_o;
  logic [3:0]    data_size_o;
  logic          parity_size_o;
  logic          parity_type_o;
  logic [1:0]    stop_size_o;
  logic [8:0]    data_i;
  logic          rx_rdy_i;
  logic          rx_err_i;
  logic          rd_valid_o;
  logic [8:0]    rd_data_o;
  logic          rd_err_o;
  logic          rd_ready_i;
  logic          overrun_o;
  logic          clr_overrun_i;
  logic [3:0]    level_o;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .DIV_W     (DW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .rx_i          (rx_i),
    .baud_div_i    (baud_div_i),
    .data_size_i   (data_size_i),
    .parity_size_i (parity_size_i),
    .parity_type_i (parity_type_i),
    .stop_size_i   (stop_size_i),
    .rx_en_o       (rx_en_o),
    .rx_o          (rx_o),
    .data_size_o   (data_size_o),
    .parity_size_o (parity_size_o),
    .parity_type_o (parity_type_o),
    .stop_size_o   (stop_size_o),
    .data_i        (data_i),
    .rx_rdy_i      (rx_rdy_i),
    .rx_err_i      (rx_err_i),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (rd_data_o),
    .rd_err_o      (rd_err_o),
    .rd_ready_i    (rd_ready_i),
    .overrun_o     (overrun_o),
    .clr_overrun_i (clr_overrun_i),
    .level_o       (level_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [9:0] sb_q[$];
  int         strb_off[$];
  logic       strb_val[$];
  int         fall_idx;

  typedef enum logic [2:0] {OP_PUSH, OP_POP, OP_PUSHPOP, OP_CLR, OP_PUSHCLR} op_e;
  typedef struct {
    op_e        op;
    logic [8:0] data;
    logic       err;
    int         exp_level;
    logic       exp_ov;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Drives the serial line one cycle at a time (bit b for bit_cyc cycles)
  // and records every strobe as an offset from START entry plus the line
  // level seen by the datapath. Optionally raises reset at a given strobe.
  task automatic run_line(input int bit_cyc, input logic [15:0] line, input int nbits,
                          input int ncyc, input int rst_at);
    fall_idx = -1;
    strb_off.delete();
    strb_val.delete();
    for (int i = 0; i < ncyc; i++) begin
      int b;
      b = i / bit_cyc;
      rx_i = (b < nbits) ? line[b] : 1'b1;
      @(negedge clk);
      if (fall_idx < 0 && rx_o == 1'b0) fall_idx = i;
      if (rx_en_o) begin
        strb_off.push_back(i - fall_idx - 1);
        strb_val.push_back(rx_o);
      end
      if (rst_at > 0 && strb_val.size() == rst_at) begin
        rst_i = 1'b1;
        rx_i  = 1'b1;
        return;
      end
    end
    rx_i = 1'b1;
  endtask

  // Stands in for the rx datapath: presents a word and raises its done level.
  task automatic push_word(input logic [8:0] d, input logic e);
    data_i   = d;
    rx_err_i = e;
    rx_rdy_i = 1'b1;
    @(negedge clk);
    rx_rdy_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_check(input string name);
    logic [9:0] exp_w;
    chk({name, "_valid"}, 32'(rd_valid_o), 32'(1));
    if (sb_q.size() == 0) begin
      chk({name, "_sb_size"}, 32'(sb_q.size()), 32'(1));
    end else if (rd_valid_o) begin
      exp_w = sb_q.pop_front();
      chk({name, "_data"}, 32'(rd_data_o), 32'(exp_w[8:0]));
      chk({name, "_err"},  32'(rd_err_o),  32'(exp_w[9]));
      rd_ready_i = 1'b1;
      @(negedge clk);
      rd_ready_i = 1'b0;
    end
  endtask

  function automatic logic [15:0] line_8n1(input logic [7:0] b);
    return {6'h3F, 1'b1, b, 1'b0};
  endfunction

  initial begin
    logic [7:0] w8;
    logic [4:0] w5;
    logic [9:0] exp_w;
    logic       do_push, do_pop, do_clr;

    // FIFO vector table
    for (int i = 0; i < 8; i++)
      vecs[i] = '{OP_PUSH, 9'(i * 37 + 5), 1'(i % 2), i + 1, 1'b0};
    vecs[8]  = '{OP_PUSH,    9'h1FF, 1'b0, 8, 1'b1};
    vecs[9]  = '{OP_CLR,     9'h000, 1'b0, 8, 1'b0};
    vecs[10] = '{OP_PUSHPOP, 9'h055, 1'b1, 8, 1'b0};
    vecs[11] = '{OP_PUSHCLR, 9'h0AA, 1'b0, 8, 1'b1};
    vecs[12] = '{OP_CLR,     9'h000, 1'b0, 8, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[13 + i] = '{OP_POP, 9'h000, 1'b0, 7 - i, 1'b0};
    vecs[21] = '{OP_POP,  9'h000, 1'b0, 0, 1'b0};
    vecs[22] = '{OP_PUSH, 9'h123, 1'b1, 1, 1'b0};
    vecs[23] = '{OP_POP,  9'h000, 1'b0, 0, 1'b0};

    rst_i = 1'b1; rx_i = 1'b1; baud_div_i = 16'd16;
    data_size_i = 4'd8; parity_size_i = 1'b0; parity_type_i = 1'b0; stop_size_i = 2'd1;
    data_i = '0; rx_rdy_i = 1'b0; rx_err_i = 1'b0; rd_ready_i = 1'b0; clr_overrun_i = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_rx_o",      32'(rx_o),        32'(1));
    chk("rst_rx_en",     32'(rx_en_o),     32'(0));
    chk("rst_valid",     32'(rd_valid_o),  32'(0));
    chk("rst_level",     32'(level_o),     32'(0));
    chk("rst_overrun",   32'(overrun_o),   32'(0));
    chk("rst_data_size", 32'(data_size_o), 32'(0));
    chk("rst_stop_size", 32'(stop_size_o), 32'(0));
    rst_i = 1'b0;
    @(negedge clk);

    // ---- FIFO table ----
    for (int v = 0; v < NV; v++) begin
      do_push = (vecs[v].op == OP_PUSH) || (vecs[v].op == OP_PUSHPOP) || (vecs[v].op == OP_PUSHCLR);
      do_pop  = (vecs[v].op == OP_POP)  || (vecs[v].op == OP_PUSHPOP);
      do_clr  = (vecs[v].op == OP_CLR)  || (vecs[v].op == OP_PUSHCLR);
      if (do_pop) begin
        chk($sformatf("v%0d_pre_valid", v), 32'(rd_valid_o), 32'(sb_q.size() != 0));
        if (rd_valid_o && sb_q.size() > 0) begin
          exp_w = sb_q.pop_front();
          chk($sformatf("v%0d_pop_data", v), 32'(rd_data_o), 32'(exp_w[8:0]));
          chk($sformatf("v%0d_pop_err", v),  32'(rd_err_o),  32'(exp_w[9]));
        end
      end
      if (do_push && sb_q.size() < DEPTH) sb_q.push_back({vecs[v].err, vecs[v].data});
      rx_rdy_i      = do_push;
      data_i        = vecs[v].data;
      rx_err_i      = vecs[v].err;
      rd_ready_i    = do_pop;
      clr_overrun_i = do_clr;
      @(negedge clk);
      rx_rdy_i = 1'b0; rd_ready_i = 1'b0; clr_overrun_i = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_level", v),   32'(level_o),    32'(vecs[v].exp_level));
      chk($sformatf("v%0d_overrun", v), 32'(overrun_o),  32'(vecs[v].exp_ov));
      chk($sformatf("v%0d_valid", v),   32'(rd_valid_o), 32'(vecs[v].exp_level != 0));
    end

    // ---- 8N1 frame 0xA5 at div=16 ----
    run_line(16, line_8n1(8'hA5), 10, 200, 0);
    chk("a5_strobes", 32'(strb_off.size()), 32'(10));
    for (int k = 0; k < 10 && k < strb_off.size(); k++)
      chk($sformatf("a5_strobe%0d_off", k), 32'(strb_off[k]), 32'(8 + 16 * k));
    chk("a5_cfg_data", 32'(data_size_o),   32'(8));
    chk("a5_cfg_par",  32'(parity_size_o), 32'(0));
    chk("a5_cfg_stop", 32'(stop_size_o),   32'(1));
    w8 = '0;
    if (strb_val.size() >= 10) begin
      chk("a5_start_lvl", 32'(strb_val[0]), 32'(0));
      chk("a5_stop_lvl",  32'(strb_val[9]), 32'(1));
      for (int j = 1; j <= 8; j++) w8[j-1] = strb_val[j];
    end
    push_word({1'b0, w8}, 1'b0);
    sb_q.push_back({1'b0, 9'h0A5});
    chk("a5_level", 32'(level_o), 32'(1));
    pop_check("a5_pop");

    // ---- 3-cycle glitch at div=16 ----
    run_line(3, 16'h0000, 1, 60, 0);
    chk("glitch_strobes", 32'(strb_off.size()), 32'(0));
    chk("glitch_level",   32'(level_o), 32'(0));

    // configuration outputs hold while idle inputs change
    baud_div_i = 16'd2; data_size_i = 4'd5; parity_size_i = 1'b1;
    parity_type_i = 1'b1; stop_size_i = 2'd2;
    repeat (3) @(negedge clk);
    chk("hold_cfg_data", 32'(data_size_o), 32'(8));
    chk("hold_cfg_stop", 32'(stop_size_o), 32'(1));

    // ---- baud_div=2 -> div=4, 5 data + parity + 2 stop ----
    run_line(4, {7'h7F, 2'b11, 1'b1, 5'h13, 1'b0}, 9, 60, 0);
    chk("d4_strobes", 32'(strb_off.size()), 32'(9));
    for (int k = 0; k < 9 && k < strb_off.size(); k++)
      chk($sformatf("d4_strobe%0d_off", k), 32'(strb_off[k]), 32'(2 + 4 * k));
    chk("d4_cfg_data", 32'(data_size_o),   32'(5));
    chk("d4_cfg_par",  32'(parity_size_o), 32'(1));
    chk("d4_cfg_ptyp", 32'(parity_type_o), 32'(1));
    chk("d4_cfg_stop", 32'(stop_size_o),   32'(2));
    w5 = '0;
    if (strb_val.size() >= 9) begin
      chk("d4_par_lvl", 32'(strb_val[6]), 32'(1));
      for (int j = 1; j <= 5; j++) w5[j-1] = strb_val[j];
    end
    push_word({4'b0, w5}, 1'b1);
    sb_q.push_back({1'b1, 9'h013});
    pop_check("d4_pop");

    // ---- reset at strobe 4 of a div=16 8N1 frame ----
    baud_div_i = 16'd16; data_size_i = 4'd8; parity_size_i = 1'b0;
    parity_type_i = 1'b0; stop_size_i = 2'd1;
    push_word(9'h07E, 1'b0);
    sb_q.push_back({1'b0, 9'h07E});
    chk("mr_pre_level", 32'(level_o), 32'(1));
    run_line(16, line_8n1(8'h5A), 10, 200, 4);
    chk("mr_reached_strobe4", 32'(strb_val.size()), 32'(4));
    @(negedge clk);
    chk("mr_rx_en",    32'(rx_en_o),     32'(0));
    chk("mr_rx_o",     32'(rx_o),        32'(1));
    chk("mr_valid",    32'(rd_valid_o),  32'(0));
    chk("mr_level",    32'(level_o),     32'(0));
    chk("mr_overrun",  32'(overrun_o),   32'(0));
    chk("mr_cfg_data", 32'(data_size_o), 32'(0));
    chk("mr_cfg_stop", 32'(stop_size_o), 32'(0));
    sb_q.delete();
    rst_i = 1'b0;
    run_line(16, 16'hFFFF, 0, 40, 0);
    chk("mr_idle_strobes", 32'(strb_off.size()), 32'(0));
    baud_div_i = 16'd4;
    run_line(4, line_8n1(8'h3C), 10, 60, 0);
    chk("mr_fresh_strobes", 32'(strb_off.size()), 32'(10));
    if (strb_off.size() > 0)
      chk("mr_fresh_first_off", 32'(strb_off[0]), 32'(2));
    chk("mr_fresh_level", 32'(level_o), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
